// File: rtl/vm_pkg.sv
// vm_pkg: shared state encoding, index-width helper and LED constant for the voting machine
package vm_pkg;
  typedef enum logic [1:0] {IDLE, ACK, RESULT} state_t;
  localparam logic [63:0] ALL_ONES = '1;
  function automatic int cand_iw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vm_debounce.sv
// vm_debounce: per-button press filter, one valid pulse after DEBOUNCE+1 consecutive high samples
module vm_debounce #(
  parameter int DEBOUNCE = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic valid
);
  localparam int CW = $clog2(DEBOUNCE + 2);
  logic [CW-1:0] cnt;
  // saturating run-length counter; the pulse fires once as it passes DEBOUNCE
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      cnt   <= !button ? '0 : (cnt == CW'(DEBOUNCE + 1)) ? cnt : cnt + 1'b1;
      valid <= button && cnt == CW'(DEBOUNCE);
    end
endmodule

// File: rtl/voting_machine_n.sv
// voting_machine_n: N-candidate ballot machine with debounce, lockout flash, result display and leader flags; VM_VOTE_CLEAR_EN enables all-button tally clear in result mode
module voting_machine_n
  import vm_pkg::*;
#(
  parameter int NUM_CAND  = 4,
  parameter int CNT_W     = 8,
  parameter int DEBOUNCE  = 10,
  parameter int FLASH_CYC = 10,
  parameter int LED_W     = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             mode,
  input  logic [NUM_CAND-1:0]              button,
  output logic [LED_W-1:0]                 led,
  output logic                             busy,
  output logic [cand_iw(NUM_CAND)-1:0]     winner_idx,
  output logic                             tie,
  output logic                             overflow
);
  localparam int CAND_IW = cand_iw(NUM_CAND);
  localparam int FW      = $clog2(FLASH_CYC + 1);
  logic [1:0]          rst_q;
  logic                rst_i;
  logic [NUM_CAND-1:0] valid;
  logic [CAND_IW-1:0]  pick, sel, lead;
  logic                any, vote, wipe, sel_ok, tie_c, seen;
  logic [FW-1:0]       fcnt;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic [CNT_W-1:0]    best;
  state_t              state, state_nx;
  // reset asserts at once, releases two edges after rst rises
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_i = rst_q[1];
  for (genvar i = 0; i < NUM_CAND; i++) begin : g_db
    vm_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (.clk(clk), .rst(rst_i), .button(button[i]), .valid(valid[i]));
  end
  // fixed-priority arbiter: lowest index pulse wins, the rest are dropped
  always_comb begin
    pick = '0;
    for (int k = NUM_CAND - 1; k >= 0; k--) pick = valid[k] ? CAND_IW'(k) : pick;
  end
  assign any  = |valid;
  assign vote = state == IDLE && !mode && any;
`ifdef VM_VOTE_CLEAR_EN
  assign wipe = state == RESULT && &valid;
`else
  assign wipe = 1'b0;
`endif
  // session state register
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= state_nx;
  // mode overrides everything; a vote opens the flash, which runs FLASH_CYC cycles
  always_comb
    state_nx = mode ? RESULT : vote ? ACK :
               (state == ACK && fcnt != FW'(FLASH_CYC - 1)) ? ACK : IDLE;
  // flash length counter, parked at zero outside ACK so each flash starts fresh
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) fcnt <= '0;
    else fcnt <= (state == ACK) ? fcnt + 1'b1 : '0;
  // display selection lives only inside RESULT
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      sel_ok <= 1'b0;
      sel    <= '0;
    end else if (state != RESULT || wipe) sel_ok <= 1'b0;
    else if (any) begin
      sel_ok <= 1'b1;
      sel    <= pick;
    end
  // saturating tallies with sticky overflow
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      for (int k = 0; k < NUM_CAND; k++) tally[k] <= '0;
      overflow <= 1'b0;
    end else if (wipe) begin
      for (int k = 0; k < NUM_CAND; k++) tally[k] <= '0;
      overflow <= 1'b0;
    end else if (vote) begin
      if (&tally[pick]) overflow <= 1'b1;
      else tally[pick] <= tally[pick] + 1'b1;
    end
  // leader search: strict compare keeps the lowest index, second hit on the max flags a tie
  always_comb begin
    best  = '0;
    lead  = '0;
    tie_c = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < NUM_CAND; k++)
      if (tally[k] > best) begin
        best = tally[k];
        lead = CAND_IW'(k);
      end
    for (int k = 0; k < NUM_CAND; k++)
      if (tally[k] == best) begin
        tie_c = tie_c | seen;
        seen  = 1'b1;
      end
  end
  // leader flags lag the tallies by one cycle
  always_ff @(posedge clk or negedge rst_i)
    if (!rst_i) begin
      winner_idx <= '0;
      tie        <= 1'b0;
    end else begin
      winner_idx <= lead;
      tie        <= tie_c;
    end
  // outputs decoded straight from state so a reset clears them without a clock
  always_comb begin
    busy = state == ACK;
    led  = busy ? LED_W'(ALL_ONES) : (state == RESULT && sel_ok) ? LED_W'(tally[sel]) : '0;
  end
endmodule

// File: tb/tb_voting_machine_n.sv
// tb_voting_machine_n: directed vector bench for voting_machine_n at default parameters
module tb_voting_machine_n;
  logic       clk = 1'b0, rst = 1'b0, mode = 1'b0;
  logic [3:0] button = '0;
  logic [7:0] led;
  logic       busy, tie, overflow;
  logic [1:0] winner_idx;
  int tests = 0, fails = 0;

  typedef struct {
    logic [3:0]  mask;
    int          hold;
    logic [31:0] tal;
    logic [1:0]  win;
    logic        tie;
  } vec_t;
  vec_t vecs[12];

  voting_machine_n dut (
    .clk(clk), .rst(rst), .mode(mode), .button(button), .led(led),
    .busy(busy), .winner_idx(winner_idx), .tie(tie), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tv(input int a0, a1, a2, a3);
    return {a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  function automatic logic [31:0] tal();
    return {dut.tally[3], dut.tally[2], dut.tally[1], dut.tally[0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    button = m;
    step(hold);
    button = '0;
    step(gap);
  endtask

  initial begin
    int n;
    vecs[0]  = '{4'b1010, 12, tv(2, 1, 1, 0), 2'd0, 1'b0};
    vecs[1]  = '{4'b0001, 11, tv(3, 1, 1, 0), 2'd0, 1'b0};
    vecs[2]  = '{4'b1000,  9, tv(3, 1, 1, 0), 2'd0, 1'b0};
    vecs[3]  = '{4'b0010, 11, tv(3, 2, 1, 0), 2'd0, 1'b0};
    vecs[4]  = '{4'b0010, 11, tv(3, 3, 1, 0), 2'd0, 1'b1};
    vecs[5]  = '{4'b0010, 11, tv(3, 4, 1, 0), 2'd1, 1'b0};
    vecs[6]  = '{4'b0010, 11, tv(3, 5, 1, 0), 2'd1, 1'b0};
    vecs[7]  = '{4'b0100, 11, tv(3, 5, 2, 0), 2'd1, 1'b0};
    vecs[8]  = '{4'b0100, 11, tv(3, 5, 3, 0), 2'd1, 1'b0};
    vecs[9]  = '{4'b0100, 11, tv(3, 5, 4, 0), 2'd1, 1'b0};
    vecs[10] = '{4'b0100, 11, tv(3, 5, 5, 0), 2'd1, 1'b1};
    vecs[11] = '{4'b0100,  9, tv(3, 5, 5, 0), 2'd1, 1'b1};

    step(3);
    chk("reset_outputs", {led, busy, winner_idx, tie, overflow}, '0);
    rst = 1'b1;
    step(5);
    chk("zero_tie", {winner_idx, tie}, {2'd0, 1'b1});
    chk("idle_led", {led, busy}, '0);

    button = 4'b0100;
    step(10);
    chk("db_early", {dut.valid, busy}, '0);
    step(1);
    chk("db_pulse", {dut.valid, busy}, {4'b0100, 1'b0});
    button = '0;
    step(1);
    chk("db_ack", {dut.valid, busy, led}, {4'b0000, 1'b1, 8'hFF});
    n = 1;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (busy && led == 8'hFF) n++;
    end
    chk("flash_len", n, 10);
    chk("flash_end", {led, busy}, '0);
    chk("db_tally", tal(), tv(0, 0, 1, 0));
    chk("db_leader", {winner_idx, tie}, {2'd2, 1'b0});
    press(4'b1000, 9, 15);
    chk("glitch", tal(), tv(0, 0, 1, 0));

    for (int e = 1; e <= 30; e++) begin
      button = {2'b00, e >= 4 && e <= 14, e <= 11 || (e >= 13 && e <= 20)};
      step(1);
      if (e == 14) chk("lock_pulse", {busy, dut.valid[1]}, 2'b11);
    end
    button = '0;
    step(10);
    chk("lockout", tal(), tv(1, 0, 1, 0));
    press(4'b0001, 11, 13);
    chk("revote", tal(), tv(2, 0, 1, 0));

    foreach (vecs[i]) begin
      press(vecs[i].mask, vecs[i].hold, 14);
      chk($sformatf("vec%0d_tally", i), tal(), vecs[i].tal);
      chk($sformatf("vec%0d_leader", i), {winner_idx, tie}, {vecs[i].win, vecs[i].tie});
      chk($sformatf("vec%0d_idle", i), {led, busy}, '0);
    end

    mode = 1'b1;
    step(2);
    chk("res_nosel", {led, busy}, '0);
    press(4'b0100, 11, 3);
    chk("res_led2", led, 8'h05);
    chk("res_novote", tal(), tv(3, 5, 5, 0));
    chk("res_leader", {winner_idx, tie}, {2'd1, 1'b1});
    press(4'b0001, 11, 3);
    chk("res_led0", led, 8'h03);
    mode = 1'b0;
    step(2);
    chk("res_exit", {led, busy}, '0);

    button = 4'b1000;
    step(11);
    button = '0;
    step(3);
    chk("abort_pre", busy, 1'b1);
    mode = 1'b1;
    step(1);
    chk("abort", {led, busy}, '0);
    mode = 1'b0;
    step(2);

    for (int i = 0; i < 255; i++) begin
      press(4'b1000, 11, 12);
      if (i == 253) chk("sat_full", {tal(), overflow}, {tv(3, 5, 5, 255), 1'b0});
    end
    chk("sat_ovf", {tal(), overflow}, {tv(3, 5, 5, 255), 1'b1});
    chk("sat_leader", {winner_idx, tie}, {2'd3, 1'b0});
    mode = 1'b1;
    step(2);
    press(4'b1000, 11, 3);
    chk("res_led3", {led, busy}, {8'hFF, 1'b0});

    press(4'b1111, 11, 3);
`ifdef VM_VOTE_CLEAR_EN
    chk("clear_tally", {tal(), overflow}, '0);
    chk("clear_led", led, 8'h00);
    step(2);
    chk("clear_leader", {winner_idx, tie}, {2'd0, 1'b1});
`else
    chk("noclear_tally", {tal(), overflow}, {tv(3, 5, 5, 255), 1'b1});
    chk("noclear_led", led, 8'h03);
`endif
    mode = 1'b0;
    step(2);

    press(4'b0010, 11, 4);
    chk("rst_pre", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk("rst_async", {led, busy, winner_idx, tie, overflow}, '0);
    chk("rst_tally", tal(), '0);
    step(2);
    rst = 1'b1;
    step(5);
    chk("rst_release", {led, busy, tie}, {8'h00, 1'b0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/voting_machine_n.md
Name: voting_machine_n

Overview:
- Parametrised next-generation ballot machine with NUM_CAND candidate buttons.
- Each button has its own debouncer. An arbiter accepts one vote per accepted press, and a session FSM locks out voting while the acknowledge LED flash is running.
- In result mode the LEDs show the tally of the selected candidate, and the block reports the current leader and a tie flag.
- Top-level block of the voting-machine design; replaces the fixed 4-candidate machine.

Parameters:
- NUM_CAND, 4, number of candidates/buttons (2..16).
- CNT_W, 8, width of each tally counter.
- DEBOUNCE, 10, number of consecutive high samples a button needs before a vote pulse is issued (>=1).
- FLASH_CYC, 10, length in cycles of the LED acknowledge flash (>=1).
- LED_W, 8, LED bus width.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low; asserts immediately, deasserts synchronously into clk domain.
- mode  in  1  0 = voting, 1 = result display.
- button  in  NUM_CAND  raw candidate buttons, active-high, already synchronised.
- led  out  LED_W  LED drive.
- busy  out  1  high while the ACK flash runs (votes locked out).
- winner_idx  out  $clog2(NUM_CAND)  index of the leading candidate.
- tie  out  1  two or more candidates share the maximum tally.
- overflow  out  1  sticky flag: a vote was received for a saturated counter.

Behaviour:
- Reset (rst=0): all debounce counters, tallies, display select and overflow are cleared; FSM goes to IDLE; led=0, busy=0, winner_idx=0, tie=0. Reset asserted mid-flash aborts immediately.
- Debounce, per button:
  - Counter increments each edge while button=1, saturating at DEBOUNCE+1; it clears on any edge where button=0.
  - valid[i] pulses for exactly one cycle, registered on the edge where the counter equals DEBOUNCE.
  - So the pulse is high in the cycle after edge DEBOUNCE+1, counting from the first high sample.
  - One pulse per press; the button must be released before it can pulse again.
- Arbitration: if several valid pulses occur in the same cycle, the lowest index wins and the others are discarded (not queued).
- FSM states IDLE, ACK, RESULT:
  - IDLE, mode=0, valid pulse k: tally[k] increments on the next edge, FSM enters ACK on the same edge, and led is all ones from that edge on.
  - ACK: holds for exactly FLASH_CYC cycles with led all ones and busy=1. Valid pulses are ignored (no vote, no queueing). Then returns to IDLE with led=0.
  - Any state, mode=1: on the next edge go to RESULT; this aborts any ACK flash. Display select resets to none, led=0.
  - RESULT: a valid pulse on button k latches select=k. Votes are never counted in RESULT.
  - RESULT with a selection: led = tally[select], zero-extended if LED_W > CNT_W, low LED_W bits if LED_W < CNT_W. The display tracks the tally live.
  - RESULT, mode=0: on the next edge go to IDLE, led=0.
- Tally arithmetic: each tally saturates at 2^CNT_W-1. A vote to a saturated counter leaves it unchanged and sets overflow, which is cleared only by reset.
- Leader: winner_idx and tie are registered one cycle after the tally update.
  - winner_idx = lowest index holding the maximum tally.
  - tie=1 if two or more candidates share that maximum, including all-zero tallies after reset once one cycle has elapsed.

Optional Feature:
- Macro VM_VOTE_CLEAR_EN.
- Defined: in RESULT, when every button is debounced-high at the same time for one cycle, all tallies and overflow clear on the next edge, and led shows 0 until the next selection.
- Undefined: that input combination has no special effect, and tallies clear only on reset.

Decomposition:
- Shared package vm_pkg holds:
  - state enum (IDLE, ACK, RESULT);
  - index width function/constant CAND_IW = $clog2(NUM_CAND) (minimum 1);
  - all-ones LED constant.
- Sub-module vm_debounce (params DEBOUNCE; ports clk, rst, button, valid), instantiated NUM_CAND times in a generate loop.
- Arbiter, FSM, tallies and leader compare stay in voting_machine_n.

Test Plan:
- Debounce: hold button[2] for 11 cycles, then release -> exactly one valid pulse in cycle 11, tally[2]=1, led=FF for 10 cycles, busy=1 during the flash. A 9-cycle glitch -> no vote.
- Arbitration: button[1] and button[3] rise on the same edge and are held 12 cycles -> tally[1]=1, tally[3]=0.
- Lockout: vote on button 0, then a second press completing while busy=1 -> tally[0]=1 only. The same press repeated after the flash ends -> tally[0]=2.
- Result display: tallies {3,5,5,0} built by voting, then mode=1 and a press on button 2 -> led=05, winner_idx=1, tie=1.
- Saturation and reset:
  - CNT_W=2 with 4 votes on button 0 -> tally[0]=3 and overflow=1.
  - Assert rst mid-ACK -> led=0, busy=0 and all tallies=0 with no clock edge.
- With VM_VOTE_CLEAR_EN: in RESULT, hold all four buttons -> tallies=0, overflow=0.
